adxl362_spi_responder: RTL and testbench
========================================

// Module: adxl362_spi_responder
// PURPOSE
//  Synthesizable SPI responder emulating the ADXL362 command/register protocol (mode 0).
//  Target-side counterpart of the SPI master/controller. Used as a bench/loopback model
//  and FPGA stand-in for the accelerometer.
//  Sensor values arrive on parallel inputs; a 64-byte register map is exposed over SPI.
// PARAMETERS
//  SYNC_STAGES  2      synchronizer depth on sclk_i/ncs_i/mosi_i (>=2)
//  DEVID_AD     8'hAD  reg 0x00 value
//  DEVID_MST    8'h1D  reg 0x01 value
//  PART_ID      8'hF2  reg 0x02 value
//  REV_ID       8'h01  reg 0x03 value
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst        in   1   synchronous reset, active-low (0 = reset)
//  sclk_i     in   1   SPI clock from master, async to clk, idle low
//  ncs_i      in   1   chip select, active-low, async
//  mosi_i     in   1   master-out data, async
//  miso_o     out  1   responder-out data
//  miso_oe    out  1   miso output enable (1 while selected)
//  x_data     in   12  X sample, two's complement
//  y_data     in   12  Y sample
//  z_data     in   12  Z sample
//  t_data     in   12  temperature sample
//  wr_stb     out  1   1-clk pulse on each accepted register write
//  wr_addr    out  6   address of accepted write (valid with wr_stb)
//  wr_data    out  8   data of accepted write (valid with wr_stb)
// BEHAVIOUR
//  - Reset values: miso_o=0, miso_oe=0, wr_stb=0, wr_addr=0, wr_data=0; state IDLE; writable regs to defaults (all 0).
//  - Inputs pass through SYNC_STAGES flops; edges are detected on the synced sclk/ncs.
//    Requirement: sclk high/low phase >= SYNC_STAGES+4 clk cycles.
//  - Bit rules: mosi sampled on detected sclk rise, MSB first; miso updated 1 clk after detected sclk fall.
//    A 3-bit counter frames bytes and clears on ncs fall.
//  - ncs fall: state IDLE->CMD; miso_oe=1; miso_o=0.
//    Snapshot x/y/z/t into shadow regs so multi-byte reads are coherent.
//  - FSM states:
//    - CMD: on byte complete, 0x0A->WADDR, 0x0B->RADDR, any other value->IGNORE.
//    - WADDR: on byte complete, addr <= byte[5:0] (bits 7:6 ignored) -> WRITE.
//    - WRITE: each completed byte written to addr, wr_stb pulsed, addr <= addr+1.
//    - RADDR: on byte complete, addr <= byte[5:0]; tx_shift <= reg[addr] -> READ.
//    - READ: MSB driven on next sclk fall; after 8 bits, addr+1 and tx_shift reloads; streams until ncs rise.
//    - IGNORE: miso_o=0; mosi discarded until ncs rise.
//  - Address wrap: 0x3F+1 -> 0x00 for both read and write.
//  - Register map:
//    - 0x00-0x03: ID parameters (RO).
//    - 0x08/09/0A: shadow x/y/z [11:4] (RO).
//    - 0x0E-0x15: X_L,X_H,Y_L,Y_H,Z_L,Z_H,T_L,T_H. L=[7:0]; H={4{sign}},[11:8] (RO).
//    - 0x20-0x2E: read/write.
//    - 0x1F: soft reset, write-only (reads 0x00).
//    - All other addresses read 0x00; writes are ignored with no wr_stb, but addr still increments.
//  - Soft reset: write 0x52 to 0x1F -> regs 0x20-0x2E return to 0 on the next clk; wr_stb still pulses.
//  - ncs rise in any state -> IDLE; miso_oe=0; partial byte discarded (no write, no wr_stb).
//  - ncs rise and sclk edge detected in the same clk: ncs rise wins.
//  - rst low mid-transaction: immediate return to reset values; the transfer is lost.
// STRUCTURE
//  - adxl362_pkg: command codes (CMD_WR=0x0A, CMD_RD=0x0B), register addresses, soft-reset key 0x52,
//    FSM state encoding, RW address range bounds.
//  - Sub-module spi_rx_sync: synchronizer chain plus rise/fall pulse generation for sclk and ncs,
//    and the synced mosi.
//  - Top level: FSM, bit/byte counters, shift registers, register file, shadow regs.
// TESTING
//  1. Reset held 4 clk mid-burst -> all outputs at reset values; next transaction works.
//  2. ncs low, send 0x0B,0x00, clock 4 bytes -> miso returns AD,1D,F2,01; miso_oe=0 after ncs rise.
//  3. Send 0x0A,0x2C,0x55,0xAA -> wr_stb x2 (2C/55, 2D/AA); read 0x2C,0x2D returns 55,AA.
//  4. Write from addr 0x3F with 0x11,0x22 -> no strobe for 0x3F; 0x00 not written;
//     addr wraps to 0x00 and then 0x01 (also RO, no strobe).
//  5. x_data=0x8F3 at ncs fall, changed mid-read; read 0x0E,0x0F -> F3,F8 (snapshot held).
//  6. Write 0x2D=0x02, then 0x1F=0x52 -> read 0x2D returns 00.
//     Cmd 0x0D -> miso all 0, no strobe.
//     ncs rise after 5 bits of data byte -> no write.

Source files
------------

// File: rtl/adxl362_spi_responder_pkg.sv
// Shared constants, register addresses and FSM encoding for the ADXL362 SPI responder.
package adxl362_spi_responder_pkg;

   localparam logic [7:0] CmdWr      = 8'h0A;
   localparam logic [7:0] CmdRd      = 8'h0B;
   localparam logic [7:0] SoftRstKey = 8'h52;

   localparam logic [5:0] AddrDevidAd  = 6'h00;
   localparam logic [5:0] AddrDevidMst = 6'h01;
   localparam logic [5:0] AddrPartId   = 6'h02;
   localparam logic [5:0] AddrRevId    = 6'h03;
   localparam logic [5:0] AddrXData8   = 6'h08;
   localparam logic [5:0] AddrYData8   = 6'h09;
   localparam logic [5:0] AddrZData8   = 6'h0A;
   localparam logic [5:0] AddrXL       = 6'h0E;
   localparam logic [5:0] AddrXH       = 6'h0F;
   localparam logic [5:0] AddrYL       = 6'h10;
   localparam logic [5:0] AddrYH       = 6'h11;
   localparam logic [5:0] AddrZL       = 6'h12;
   localparam logic [5:0] AddrZH       = 6'h13;
   localparam logic [5:0] AddrTL       = 6'h14;
   localparam logic [5:0] AddrTH       = 6'h15;
   localparam logic [5:0] AddrSoftRst  = 6'h1F;
   localparam logic [5:0] AddrRwLo     = 6'h20;
   localparam logic [5:0] AddrRwHi     = 6'h2E;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StWaddr,
      StWrite,
      StRaddr,
      StRead,
      StIgnore
   } state_e;

   function automatic logic is_rw_addr(logic [5:0] a);
      return (a >= AddrRwLo) && (a <= AddrRwHi);
   endfunction

   // High byte of a 12-bit sample: sign-extended upper nibble.
   function automatic logic [7:0] sext_hi(logic [11:0] v);
      return {{4{v[11]}}, v[11:8]};
   endfunction

endpackage

// File: rtl/adxl362_spi_responder_if.sv
// SPI pins plus register-write notification bundle of the ADXL362 responder.
interface adxl362_spi_responder_if;
   logic       sclk_i;
   logic       ncs_i;
   logic       mosi_i;
   logic       miso_o;
   logic       miso_oe;
   logic       wr_stb;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;

   modport master (
      output sclk_i, ncs_i, mosi_i,
      input  miso_o, miso_oe, wr_stb, wr_addr, wr_data
   );

   modport slave (
      input  sclk_i, ncs_i, mosi_i,
      output miso_o, miso_oe, wr_stb, wr_addr, wr_data
   );
endinterface

// File: rtl/adxl362_spi_responder_spi_rx_sync.sv
// Synchronizes the asynchronous SPI pins into clk and produces sclk/ncs edge pulses.
module adxl362_spi_responder_spi_rx_sync #(
   parameter int unsigned SyncStages = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk_i,
   input  logic ncs_i,
   input  logic mosi_i,
   output logic sclk_rise_o,
   output logic sclk_fall_o,
   output logic ncs_rise_o,
   output logic ncs_fall_o,
   output logic mosi_o
);

   logic [SyncStages-1:0] sclk_sync_q;
   logic [SyncStages-1:0] ncs_sync_q;
   logic [SyncStages-1:0] mosi_sync_q;
   logic                  sclk_prev_q;
   logic                  ncs_prev_q;

   // Reset to the idle bus levels so leaving reset does not fake an edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sclk_sync_q <= '0;
         ncs_sync_q  <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         ncs_prev_q  <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], sclk_i};
         ncs_sync_q  <= {ncs_sync_q[SyncStages-2:0], ncs_i};
         mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], mosi_i};
         sclk_prev_q <= sclk_sync_q[SyncStages-1];
         ncs_prev_q  <= ncs_sync_q[SyncStages-1];
      end
   end

   always_comb begin
      sclk_rise_o = sclk_sync_q[SyncStages-1] & ~sclk_prev_q;
      sclk_fall_o = ~sclk_sync_q[SyncStages-1] & sclk_prev_q;
      ncs_rise_o  = ncs_sync_q[SyncStages-1] & ~ncs_prev_q;
      ncs_fall_o  = ~ncs_sync_q[SyncStages-1] & ncs_prev_q;
      mosi_o      = mosi_sync_q[SyncStages-1];
   end

endmodule

// File: rtl/adxl362_spi_responder.sv
// SPI mode-0 target emulating the ADXL362 command set over a 64-byte register map.
module adxl362_spi_responder
   import adxl362_spi_responder_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  DEVID_AD    = 8'hAD,
   parameter logic [7:0]  DEVID_MST   = 8'h1D,
   parameter logic [7:0]  PART_ID     = 8'hF2,
   parameter logic [7:0]  REV_ID      = 8'h01
) (
   input  logic                          clk,
   input  logic                          rst,
   adxl362_spi_responder_if.slave        bus,
   input  logic [11:0]                   x_data,
   input  logic [11:0]                   y_data,
   input  logic [11:0]                   z_data,
   input  logic [11:0]                   t_data
);

   logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, mosi_s;

   adxl362_spi_responder_spi_rx_sync #(
      .SyncStages (SYNC_STAGES)
   ) u_sync (
      .clk         (clk),
      .rst         (rst),
      .sclk_i      (bus.sclk_i),
      .ncs_i       (bus.ncs_i),
      .mosi_i      (bus.mosi_i),
      .sclk_rise_o (sclk_rise),
      .sclk_fall_o (sclk_fall),
      .ncs_rise_o  (ncs_rise),
      .ncs_fall_o  (ncs_fall),
      .mosi_o      (mosi_s)
   );

   state_e      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [5:0]  addr_q, addr_d;
   logic        miso_q, miso_d;
   logic        miso_oe_q, miso_oe_d;
   logic        wr_stb_q, wr_stb_d;
   logic [5:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic [11:0] x_sh_q, x_sh_d, y_sh_q, y_sh_d, z_sh_q, z_sh_d, t_sh_q, t_sh_d;
   // Indexed by addr[3:0] over 0x20-0x2F; entry 15 (0x2F) is never written and reads 0.
   logic [7:0]  rw_q [16];
   logic [7:0]  rw_d [16];

   logic [7:0]  rx_byte;
   logic        byte_done;
   logic [5:0]  addr_inc;
   logic [5:0]  rd_addr;
   logic [7:0]  rd_data;

   assign rx_byte   = {rx_shift_q, mosi_s};
   assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
   assign addr_inc  = addr_q + 6'd1;
   assign rd_addr   = (state_q == StRaddr) ? rx_byte[5:0] : addr_inc;

   always_comb begin
      rd_data = '0;
      if (rd_addr[5:4] == 2'b10) begin
         rd_data = rw_q[rd_addr[3:0]];
      end else begin
         case (rd_addr)
            AddrDevidAd:  rd_data = DEVID_AD;
            AddrDevidMst: rd_data = DEVID_MST;
            AddrPartId:   rd_data = PART_ID;
            AddrRevId:    rd_data = REV_ID;
            AddrXData8:   rd_data = x_sh_q[11:4];
            AddrYData8:   rd_data = y_sh_q[11:4];
            AddrZData8:   rd_data = z_sh_q[11:4];
            AddrXL:       rd_data = x_sh_q[7:0];
            AddrXH:       rd_data = sext_hi(x_sh_q);
            AddrYL:       rd_data = y_sh_q[7:0];
            AddrYH:       rd_data = sext_hi(y_sh_q);
            AddrZL:       rd_data = z_sh_q[7:0];
            AddrZH:       rd_data = sext_hi(z_sh_q);
            AddrTL:       rd_data = t_sh_q[7:0];
            AddrTH:       rd_data = sext_hi(t_sh_q);
            default:      rd_data = '0;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      addr_d     = addr_q;
      miso_d     = miso_q;
      miso_oe_d  = miso_oe_q;
      wr_stb_d   = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      x_sh_d     = x_sh_q;
      y_sh_d     = y_sh_q;
      z_sh_d     = z_sh_q;
      t_sh_d     = t_sh_q;
      rw_d       = rw_q;

      // Chip-select edges take priority over any coincident sclk edge.
      if (ncs_rise) begin
         state_d   = StIdle;
         miso_oe_d = 1'b0;
         miso_d    = 1'b0;
         bit_cnt_d = '0;
      end else if (ncs_fall) begin
         state_d    = StCmd;
         miso_oe_d  = 1'b1;
         miso_d     = 1'b0;
         bit_cnt_d  = '0;
         tx_shift_d = '0;
         x_sh_d     = x_data;
         y_sh_d     = y_data;
         z_sh_d     = z_data;
         t_sh_d     = t_data;
      end else if (state_q != StIdle) begin
         if (sclk_rise) begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            rx_shift_d = rx_byte[6:0];
         end
         if (sclk_fall) begin
            if (state_q == StRead) begin
               miso_d     = tx_shift_q[7];
               tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end else begin
               miso_d = 1'b0;
            end
         end
         if (byte_done) begin
            unique case (state_q)
               StCmd: begin
                  if (rx_byte == CmdWr)      state_d = StWaddr;
                  else if (rx_byte == CmdRd) state_d = StRaddr;
                  else                       state_d = StIgnore;
               end
               StWaddr: begin
                  addr_d  = rx_byte[5:0];
                  state_d = StWrite;
               end
               StWrite: begin
                  if (is_rw_addr(addr_q)) begin
                     rw_d[addr_q[3:0]] = rx_byte;
                     wr_stb_d          = 1'b1;
                     wr_addr_d         = addr_q;
                     wr_data_d         = rx_byte;
                  end else if (addr_q == AddrSoftRst) begin
                     wr_stb_d  = 1'b1;
                     wr_addr_d = addr_q;
                     wr_data_d = rx_byte;
                     if (rx_byte == SoftRstKey) begin
                        for (int i = 0; i < 16; i++) rw_d[i] = '0;
                     end
                  end
                  addr_d = addr_inc;
               end
               StRaddr: begin
                  addr_d     = rx_byte[5:0];
                  tx_shift_d = rd_data;
                  state_d    = StRead;
               end
               StRead: begin
                  addr_d     = addr_inc;
                  tx_shift_d = rd_data;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         addr_q     <= '0;
         miso_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
         wr_stb_q   <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         x_sh_q     <= '0;
         y_sh_q     <= '0;
         z_sh_q     <= '0;
         t_sh_q     <= '0;
         for (int i = 0; i < 16; i++) rw_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         addr_q     <= addr_d;
         miso_q     <= miso_d;
         miso_oe_q  <= miso_oe_d;
         wr_stb_q   <= wr_stb_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         x_sh_q     <= x_sh_d;
         y_sh_q     <= y_sh_d;
         z_sh_q     <= z_sh_d;
         t_sh_q     <= t_sh_d;
         rw_q       <= rw_d;
      end
   end

   assign bus.miso_o  = miso_q;
   assign bus.miso_oe = miso_oe_q;
   assign bus.wr_stb  = wr_stb_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Self-checking bench: vector table plus directed multi-byte SPI sequences with a scoreboard.
module tb_adxl362_spi_responder;

   localparam int Half = 8;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       exp_stb;
      logic [7:0] exp_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] x_data, y_data, z_data, t_data;

   always #5 clk = ~clk;

   adxl362_spi_responder_if bus ();

   adxl362_spi_responder dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .x_data (x_data),
      .y_data (y_data),
      .z_data (z_data),
      .t_data (t_data)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_rd_q[$];
   logic [13:0] exp_stb_q[$];
   logic [13:0] got_stb_q[$];
   vec_t        vecs[7];

   always @(negedge clk) begin
      if (rst && bus.wr_stb) got_stb_q.push_back({bus.wr_addr, bus.wr_data});
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_shift(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < nbits; i++) begin
         bus.mosi_i = tx[7-i];
         wait_clk(Half);
         rx[7-i] = bus.miso_o;
         bus.sclk_i = 1'b1;
         wait_clk(Half);
         bus.sclk_i = 1'b0;
      end
   endtask

   task automatic spi_begin();
      bus.ncs_i = 1'b0;
      wait_clk(Half);
   endtask

   task automatic spi_end();
      wait_clk(Half);
      bus.ncs_i = 1'b1;
      wait_clk(Half);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d [4], input int n);
      logic [7:0] rx;
      spi_begin();
      spi_shift(8'h0A, 8, rx);
      spi_shift(a, 8, rx);
      for (int i = 0; i < n; i++) spi_shift(d[i], 8, rx);
      spi_end();
   endtask

   task automatic do_read(input logic [7:0] a, input int n, input string name);
      logic [7:0] rx;
      spi_begin();
      spi_shift(8'h0B, 8, rx);
      spi_shift(a, 8, rx);
      for (int i = 0; i < n; i++) begin
         spi_shift(8'h00, 8, rx);
         if (exp_rd_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %h, required no byte", name, rx);
         end else begin
            check(name, {8'h00, rx}, {8'h00, exp_rd_q.pop_front()});
         end
      end
      spi_end();
   endtask

   task automatic check_stb(input string name);
      while (exp_stb_q.size() != 0) begin
         if (got_stb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no strobe, required %h", name, exp_stb_q.pop_front());
         end else begin
            check(name, {2'b00, got_stb_q.pop_front()}, {2'b00, exp_stb_q.pop_front()});
         end
      end
      check({name, "_extra"}, 16'(got_stb_q.size()), 16'd0);
      got_stb_q.delete();
   endtask

   initial begin
      logic [7:0] rx;
      vecs[0] = '{addr: 8'h20, wdata: 8'h5A, exp_stb: 1'b1, exp_rd: 8'h5A};
      vecs[1] = '{addr: 8'h2E, wdata: 8'hC3, exp_stb: 1'b1, exp_rd: 8'hC3};
      vecs[2] = '{addr: 8'h2F, wdata: 8'h77, exp_stb: 1'b0, exp_rd: 8'h00};
      vecs[3] = '{addr: 8'h1E, wdata: 8'h33, exp_stb: 1'b0, exp_rd: 8'h00};
      vecs[4] = '{addr: 8'h03, wdata: 8'h99, exp_stb: 1'b0, exp_rd: 8'h01};
      vecs[5] = '{addr: 8'h1F, wdata: 8'h00, exp_stb: 1'b1, exp_rd: 8'h00};
      vecs[6] = '{addr: 8'h10, wdata: 8'h12, exp_stb: 1'b0, exp_rd: 8'h23};

      rst = 1'b0;
      bus.ncs_i = 1'b1;
      bus.sclk_i = 1'b0;
      bus.mosi_i = 1'b0;
      x_data = 12'h000;
      y_data = 12'h123;
      z_data = 12'h7FF;
      t_data = 12'h800;
      wait_clk(4);
      check("rst_miso_oe", {15'd0, bus.miso_oe}, 16'd0);
      check("rst_wr_stb", {15'd0, bus.wr_stb}, 16'd0);
      rst = 1'b1;
      wait_clk(4);

      // ID burst read
      exp_rd_q.push_back(8'hAD);
      exp_rd_q.push_back(8'h1D);
      exp_rd_q.push_back(8'hF2);
      exp_rd_q.push_back(8'h01);
      spi_begin();
      check("oe_selected", {15'd0, bus.miso_oe}, 16'd1);
      spi_shift(8'h0B, 8, rx);
      spi_shift(8'h00, 8, rx);
      for (int i = 0; i < 4; i++) begin
         spi_shift(8'h00, 8, rx);
         check("id_read", {8'h00, rx}, {8'h00, exp_rd_q.pop_front()});
      end
      spi_end();
      check("oe_deselected", {15'd0, bus.miso_oe}, 16'd0);

      // Two-byte write burst and readback
      exp_stb_q.push_back({6'h2C, 8'h55});
      exp_stb_q.push_back({6'h2D, 8'hAA});
      do_write(8'h2C, '{8'h55, 8'hAA, 8'h00, 8'h00}, 2);
      check_stb("burst_wr_stb");
      exp_rd_q.push_back(8'h55);
      exp_rd_q.push_back(8'hAA);
      do_read(8'h2C, 2, "burst_rd");

      foreach (vecs[i]) begin
         if (vecs[i].exp_stb) exp_stb_q.push_back({vecs[i].addr[5:0], vecs[i].wdata});
         do_write(vecs[i].addr, '{vecs[i].wdata, 8'h00, 8'h00, 8'h00}, 1);
         check_stb("vec_stb");
         exp_rd_q.push_back(vecs[i].exp_rd);
         do_read(vecs[i].addr, 1, "vec_rd");
      end

      // Reset asserted in the middle of a write data byte
      spi_begin();
      spi_shift(8'h0A, 8, rx);
      spi_shift(8'h21, 8, rx);
      spi_shift(8'hFF, 4, rx);
      rst = 1'b0;
      wait_clk(4);
      check("midrst_miso", {15'd0, bus.miso_o}, 16'd0);
      check("midrst_oe", {15'd0, bus.miso_oe}, 16'd0);
      check("midrst_stb", {15'd0, bus.wr_stb}, 16'd0);
      check("midrst_waddr", {10'd0, bus.wr_addr}, 16'd0);
      check("midrst_wdata", {8'd0, bus.wr_data}, 16'd0);
      bus.ncs_i = 1'b1;
      bus.sclk_i = 1'b0;
      got_stb_q.delete();
      wait_clk(2);
      rst = 1'b1;
      wait_clk(4);
      exp_rd_q.push_back(8'h00);
      exp_rd_q.push_back(8'h00);
      do_read(8'h2C, 2, "post_rst_rw");
      exp_rd_q.push_back(8'hAD);
      do_read(8'h00, 1, "post_rst_id");

      // Write starting at 0x3F wraps into read-only space
      do_write(8'h3F, '{8'h11, 8'h22, 8'h00, 8'h00}, 2);
      check_stb("wrap_wr_stb");
      exp_rd_q.push_back(8'hAD);
      exp_rd_q.push_back(8'h1D);
      do_read(8'h00, 2, "wrap_ro");
      exp_rd_q.push_back(8'h00);
      exp_rd_q.push_back(8'hAD);
      do_read(8'h3F, 2, "wrap_rd");

      // Snapshot coherence: sample changes after chip-select fall
      x_data = 12'h8F3;
      spi_begin();
      spi_shift(8'h0B, 8, rx);
      spi_shift(8'h0E, 8, rx);
      x_data = 12'h123;
      spi_shift(8'h00, 8, rx);
      check("snap_xl", {8'h00, rx}, 16'h00F3);
      spi_shift(8'h00, 8, rx);
      check("snap_xh", {8'h00, rx}, 16'h00F8);
      spi_end();

      // Soft reset clears the read/write bank
      exp_stb_q.push_back({6'h2D, 8'h02});
      do_write(8'h2D, '{8'h02, 8'h00, 8'h00, 8'h00}, 1);
      check_stb("pre_srst_stb");
      exp_rd_q.push_back(8'h02);
      do_read(8'h2D, 1, "pre_srst_rd");
      exp_stb_q.push_back({6'h1F, 8'h52});
      do_write(8'h1F, '{8'h52, 8'h00, 8'h00, 8'h00}, 1);
      check_stb("srst_stb");
      exp_rd_q.push_back(8'h00);
      do_read(8'h2D, 1, "post_srst_rd");

      // Unknown command is ignored
      spi_begin();
      spi_shift(8'h0D, 8, rx);
      spi_shift(8'hFF, 8, rx);
      check("ign_miso0", {8'h00, rx}, 16'h0000);
      spi_shift(8'h2A, 8, rx);
      check("ign_miso1", {8'h00, rx}, 16'h0000);
      spi_end();
      check_stb("ign_stb");

      // Chip-select rise mid data byte discards it
      spi_begin();
      spi_shift(8'h0A, 8, rx);
      spi_shift(8'h22, 8, rx);
      spi_shift(8'hFF, 5, rx);
      spi_end();
      check_stb("partial_stb");
      exp_rd_q.push_back(8'h00);
      do_read(8'h22, 1, "partial_rd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
